// File: rtl/icg_ctrl_pkg.sv
// icg_ctrl_pkg
// Types and helpers shared by the ICG enable controller and its idle counter:
//   - icg_state_t : controller state encoding (2 bits)
//   - WAKE_CNT_W  : width of the wake-settle counter
//   - sat_inc32   : 32-bit saturating increment (used by the gated-cycle stats)
package icg_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        OFF   = 2'd2,
        WAKE  = 2'd3
    } icg_state_t;

    localparam int WAKE_CNT_W = 4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/icg_enable_ctrl_idle_counter.sv
// icg_idle_counter
// Idle-cycle counter for the ICG enable controller. Clear has priority over
// increment; tc flags that the count has reached IDLE_CYCLES-1, i.e. the
// current cycle is the last idle cycle before gating.
// Ports:
//   clk, rst : free-running clock, async active-high reset
//   clr      : clear count to zero
//   inc      : increment count
//   tc       : terminal count (count == IDLE_CYCLES-1)
module icg_idle_counter #(
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/icg_enable_ctrl.sv
// icg_enable_ctrl
// Enable-side controller for an integrated clock gate. Runs on the ungated
// clock, drops E after IDLE_CYCLES quiet cycles, and restores it on a
// WAKE_REQ/WAKE_ACK handshake. TE follows SCAN_EN combinationally.
// Optional build macro ICG_CTRL_STATS_EN adds GATED_CNT, a saturating count
// of cycles spent gated.
// Ports:
//   CLK, RST  : free-running clock, async active-high reset
//   BUSY      : domain has work in flight (blocks/aborts gating)
//   WAKE_REQ  : level wake request, held until WAKE_ACK
//   SCAN_EN   : scan mode, freezes state and forces E
//   FORCE_ON  : software override, keeps E=1
//   E, TE     : ICG enable / test enable
//   WAKE_ACK  : one-cycle pulse, gated clock running
//   GATED     : 1 while in OFF
//   GATED_CNT : (ICG_CTRL_STATS_EN only) cycles with GATED=1
//
// state | meaning
// RUN   | clock running, idle counter clear
// COUNT | clock running, counting quiet cycles toward gating
// OFF   | clock gated (E=0)
// WAKE  | E restored, waiting WAKE_CYCLES for the gated clock to settle
module icg_enable_ctrl
    import icg_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BUSY,
    input  logic        WAKE_REQ,
    input  logic        SCAN_EN,
    input  logic        FORCE_ON,
    output logic        E,
    output logic        TE,
    output logic        WAKE_ACK,
    output logic        GATED
`ifdef ICG_CTRL_STATS_EN
   ,output logic [31:0] GATED_CNT
`endif
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);

    icg_state_t            state;
    logic [WAKE_CNT_W-1:0] wake_cnt;
    logic                  ack_suppress;
    logic                  ack_done;
    logic                  quiet;
    logic                  idle_tc;
    logic                  idle_clr;
    logic                  idle_inc;

    assign quiet = !BUSY && !WAKE_REQ && !FORCE_ON;
    assign TE    = SCAN_EN;

    // The RUN cycle counts as the first idle cycle, so a quiet RUN with the
    // counter at IDLE_CYCLES-1 (only possible for IDLE_CYCLES=1) gates at once.
    always_comb begin
        idle_clr = 1'b0;
        idle_inc = 1'b0;
        if (!SCAN_EN) begin
            if ((state == RUN || state == COUNT) && quiet && !idle_tc) begin
                idle_inc = 1'b1;
            end else begin
                idle_clr = 1'b1;
            end
        end
    end

    icg_idle_counter #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_idle_counter (
        .clk (CLK),
        .rst (RST),
        .clr (idle_clr),
        .inc (idle_inc),
        .tc  (idle_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= RUN;
            E            <= 1'b1;
            WAKE_ACK     <= 1'b0;
            GATED        <= 1'b0;
            wake_cnt     <= '0;
            ack_suppress <= 1'b0;
            ack_done     <= 1'b0;
        end else if (SCAN_EN) begin
            // State frozen; clock forced through the functional path as well.
            E        <= 1'b1;
            WAKE_ACK <= 1'b0;
        end else begin
            E        <= 1'b1;
            GATED    <= 1'b0;
            WAKE_ACK <= 1'b0;
            // A request must drop for a cycle before it can be acked again.
            if (!WAKE_REQ) begin
                ack_done <= 1'b0;
            end
            case (state)
                RUN, COUNT: begin
                    if (WAKE_REQ && !ack_done) begin
                        WAKE_ACK <= 1'b1;
                        ack_done <= 1'b1;
                    end
                    if (!quiet) begin
                        state <= RUN;
                    end else if (idle_tc) begin
                        state <= OFF;
                        E     <= 1'b0;
                        GATED <= 1'b1;
                    end else begin
                        state <= COUNT;
                    end
                end
                OFF: begin
                    if (!quiet) begin
                        state        <= WAKE;
                        wake_cnt     <= '0;
                        // BUSY alone is a protocol error: wake silently.
                        ack_suppress <= !WAKE_REQ && !FORCE_ON;
                    end else begin
                        E     <= 1'b0;
                        GATED <= 1'b1;
                    end
                end
                WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state <= RUN;
                        if (!ack_suppress && !ack_done) begin
                            WAKE_ACK <= 1'b1;
                            ack_done <= 1'b1;
                        end
                    end else begin
                        wake_cnt <= wake_cnt + WAKE_CNT_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef ICG_CTRL_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GATED_CNT <= '0;
        end else if (!SCAN_EN && GATED) begin
            GATED_CNT <= sat_inc32(GATED_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_icg_enable_ctrl.sv
module tb_icg_enable_ctrl;

    logic CLK = 1'b0;
    logic RST, BUSY, WAKE_REQ, SCAN_EN, FORCE_ON;
    logic E, TE, WAKE_ACK, GATED;
    logic e1, te1, ack1, gated1;
`ifdef ICG_CTRL_STATS_EN
    logic [31:0] gated_cnt, gated_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    icg_enable_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST), .BUSY(BUSY), .WAKE_REQ(WAKE_REQ),
        .SCAN_EN(SCAN_EN), .FORCE_ON(FORCE_ON),
        .E(E), .TE(TE), .WAKE_ACK(WAKE_ACK), .GATED(GATED)
`ifdef ICG_CTRL_STATS_EN
       ,.GATED_CNT(gated_cnt)
`endif
    );

    icg_enable_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(2), .CNT_W(5)) dut1 (
        .CLK(CLK), .RST(RST), .BUSY(BUSY), .WAKE_REQ(WAKE_REQ),
        .SCAN_EN(SCAN_EN), .FORCE_ON(FORCE_ON),
        .E(e1), .TE(te1), .WAKE_ACK(ack1), .GATED(gated1)
`ifdef ICG_CTRL_STATS_EN
       ,.GATED_CNT(gated_cnt1)
`endif
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Leaves reset at 1 ns after an edge with all inputs quiet.
    task automatic do_reset();
        RST = 1'b1; BUSY = 1'b1; WAKE_REQ = 1'b0; SCAN_EN = 1'b0; FORCE_ON = 1'b0;
        tick(2);
        RST = 1'b0; BUSY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; BUSY = 1'b0; WAKE_REQ = 1'b1; SCAN_EN = 1'b0; FORCE_ON = 1'b0;
        tick(2);
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL reset_e: E=%b expected 1", E); end
        n_checks++; if (WAKE_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: WAKE_ACK=%b expected 0", WAKE_ACK); end
        n_checks++; if (GATED !== 1'b0) begin n_fail++; $display("FAIL reset_gated: GATED=%b expected 0", GATED); end
        n_checks++; if (TE !== 1'b0) begin n_fail++; $display("FAIL reset_te0: TE=%b expected 0", TE); end
        SCAN_EN = 1'b1; #1;
        n_checks++; if (TE !== 1'b1) begin n_fail++; $display("FAIL reset_te1: TE=%b expected 1", TE); end
        SCAN_EN = 1'b0; WAKE_REQ = 1'b0;
    endtask

    task automatic test_idle_timeout();
        do_reset();
        tick(1);
        n_checks++; if (e1 !== 1'b0) begin n_fail++; $display("FAIL idle1_e: E=%b expected 0", e1); end
        n_checks++; if (gated1 !== 1'b1) begin n_fail++; $display("FAIL idle1_gated: GATED=%b expected 1", gated1); end
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL idle16_e_early1: E=%b expected 1", E); end
        tick(14);
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL idle16_e_at15: E=%b expected 1", E); end
        n_checks++; if (GATED !== 1'b0) begin n_fail++; $display("FAIL idle16_gated_at15: GATED=%b expected 0", GATED); end
        tick(1);
        n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL idle16_e_at16: E=%b expected 0", E); end
        n_checks++; if (GATED !== 1'b1) begin n_fail++; $display("FAIL idle16_gated_at16: GATED=%b expected 1", GATED); end
    endtask

    task automatic test_abort();
        do_reset();
        tick(10);
        BUSY = 1'b1;
        tick(1);
        BUSY = 1'b0;
        tick(15);
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL abort_e_at15: E=%b expected 1", E); end
        tick(1);
        n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL abort_e_at16: E=%b expected 0", E); end
    endtask

    task automatic test_wake();
        int acks;
        // Arrives here in OFF from test_abort.
        WAKE_REQ = 1'b1;
        tick(1);
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL wake_e: E=%b expected 1", E); end
        n_checks++; if (GATED !== 1'b0) begin n_fail++; $display("FAIL wake_gated: GATED=%b expected 0", GATED); end
        n_checks++; if (WAKE_ACK !== 1'b0) begin n_fail++; $display("FAIL wake_ack_c1: WAKE_ACK=%b expected 0", WAKE_ACK); end
        tick(1);
        n_checks++; if (WAKE_ACK !== 1'b0) begin n_fail++; $display("FAIL wake_ack_c2: WAKE_ACK=%b expected 0", WAKE_ACK); end
        tick(1);
        n_checks++; if (WAKE_ACK !== 1'b1) begin n_fail++; $display("FAIL wake_ack_c3: WAKE_ACK=%b expected 1", WAKE_ACK); end
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (WAKE_ACK === 1'b1) acks++;
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL wake_no_second_ack: acks=%0d expected 0", acks); end
        // Request in RUN/COUNT acks on the next cycle.
        WAKE_REQ = 1'b0;
        tick(2);
        WAKE_REQ = 1'b1;
        tick(1);
        n_checks++; if (WAKE_ACK !== 1'b1) begin n_fail++; $display("FAIL run_ack: WAKE_ACK=%b expected 1", WAKE_ACK); end
        tick(1);
        n_checks++; if (WAKE_ACK !== 1'b0) begin n_fail++; $display("FAIL run_ack_pulse: WAKE_ACK=%b expected 0", WAKE_ACK); end
        WAKE_REQ = 1'b0;
    endtask

    task automatic test_busy_in_off();
        int acks;
        do_reset();
        tick(16);
        BUSY = 1'b1;
        tick(1);
        BUSY = 1'b0;
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL busy_off_e: E=%b expected 1", E); end
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (WAKE_ACK === 1'b1) acks++;
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL busy_off_no_ack: acks=%0d expected 0", acks); end
    endtask

    task automatic test_force_on();
        do_reset();
        FORCE_ON = 1'b1;
        tick(30);
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL force_hold_e: E=%b expected 1", E); end
        FORCE_ON = 1'b0;
        tick(16);
        n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL force_release_e: E=%b expected 0", E); end
        FORCE_ON = 1'b1;
        tick(1);
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL force_wake_e: E=%b expected 1", E); end
        FORCE_ON = 1'b0;
    endtask

    task automatic test_scan();
        do_reset();
        tick(16);
        SCAN_EN = 1'b1; #1;
        n_checks++; if (TE !== 1'b1) begin n_fail++; $display("FAIL scan_te: TE=%b expected 1", TE); end
        n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL scan_e_before_edge: E=%b expected 0", E); end
        tick(1);
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL scan_e: E=%b expected 1", E); end
        tick(5);
        n_checks++; if (GATED !== 1'b1) begin n_fail++; $display("FAIL scan_state_held: GATED=%b expected 1", GATED); end
        SCAN_EN = 1'b0;
        tick(1);
        n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL scan_exit_e: E=%b expected 0", E); end
        n_checks++; if (GATED !== 1'b1) begin n_fail++; $display("FAIL scan_exit_gated: GATED=%b expected 1", GATED); end
    endtask

    task automatic test_reset_mid_wake();
        do_reset();
        tick(16);
        RST = 1'b1; #1;
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL rst_off_async_e: E=%b expected 1", E); end
        n_checks++; if (GATED !== 1'b0) begin n_fail++; $display("FAIL rst_off_gated: GATED=%b expected 0", GATED); end
        do_reset();
        tick(16);
        WAKE_REQ = 1'b1;
        tick(2);
        RST = 1'b1; #1;
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL rst_wake_e: E=%b expected 1", E); end
        tick(2);
        n_checks++; if (WAKE_ACK !== 1'b0) begin n_fail++; $display("FAIL rst_wake_ack: WAKE_ACK=%b expected 0", WAKE_ACK); end
        WAKE_REQ = 1'b0;
        RST = 1'b0;
        tick(1);
        n_checks++; if (WAKE_ACK !== 1'b0) begin n_fail++; $display("FAIL rst_wake_ack_after: WAKE_ACK=%b expected 0", WAKE_ACK); end
        tick(14);
        n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL rst_wake_run_e15: E=%b expected 1", E); end
        tick(1);
        n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL rst_wake_run_e16: E=%b expected 0", E); end
    endtask

`ifdef ICG_CTRL_STATS_EN
    task automatic test_stats();
        do_reset();
        tick(16);
        tick(20);
        n_checks++; if (gated_cnt !== 32'd20) begin n_fail++; $display("FAIL stats_cnt: GATED_CNT=%0d expected 20", gated_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_timeout();
        test_abort();
        test_wake();
        test_busy_in_off();
        test_force_on();
        test_scan();
        test_reset_mid_wake();
`ifdef ICG_CTRL_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
